// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and ROM window constants.
package riscv_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] ROM_BASE     = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES    = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats drop; hold otherwise.
module if_id_reg
  import riscv_pkg::if_id_t;
#(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   drop,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.fault    <= 1'b0;
    end else if (flush) begin
      valid   <= 1'b0;
      q.fault <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      // accepted fault marker: payload kept, only the valid bit falls
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ROM window check, RUN/HALT control, IF/ID capture.
module fetch_stage
  import riscv_pkg::fetch_state_t, riscv_pkg::if_id_t, riscv_pkg::RUN, riscv_pkg::HALT;
#(
  parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
  parameter logic [31:0] ROM_BASE     = riscv_pkg::ROM_BASE,
  parameter int unsigned ROM_BYTES    = riscv_pkg::ROM_BYTES,
  parameter logic [31:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault,
  output logic        halted
);
  localparam logic [32:0] LAST_OFF = 33'(ROM_BYTES - 4);

  logic [31:0]  pc, pc_plus4;
  logic [32:0]  off;
  fetch_state_t state;
  if_id_t       d, q;
  logic         in_range, advance, load, drop;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // 33-bit offset so addresses below ROM_BASE cannot wrap into the window
  always_comb begin
    off      = {1'b0, pc} - {1'b0, ROM_BASE};
    in_range = ({1'b0, pc} >= {1'b0, ROM_BASE}) && (off <= LAST_OFF) && (pc[1:0] == 2'b00);
  end

  assign advance = !if_valid || id_ready;
  assign load    = !redirect_valid && (state == RUN) && advance;
  assign drop    = !redirect_valid && (state == HALT) && if_valid && id_ready;

  always_comb begin
    d.pc       = pc;
    d.pc_plus4 = pc_plus4;
    d.instr    = in_range ? imem_rdata : NOP_INSTR;
    d.fault    = !in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_VECTOR;
      state <= RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      state <= RUN;
    end else if (load) begin
      if (in_range) pc <= pc_plus4;
      else          state <= HALT;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (redirect_valid),
    .drop  (drop),
    .d     (d),
    .valid (if_valid),
    .q     (q)
  );

  assign if_instr    = q.instr;
  assign if_pc       = q.pc;
  assign if_pc_plus4 = q.pc_plus4;
  assign if_fault    = q.fault;
  assign halted      = (state == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, corner sequences, random vs reference model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;
  logic        if_valid, if_fault, halted;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .id_ready(id_ready),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_fault(if_fault), .halted(halted)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - ROM_BASE) >> 2;
    if (idx < 3) return 32'h1111_1111 * (idx + 1);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always_comb imem_rdata = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] tgt, input logic rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic f, input logic h,
                         input logic [31:0] addr);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".addr"}, imem_addr, addr);
    if (v) begin
      chk({tag, ".pc"}, if_pc, pc);
      chk({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
      chk({tag, ".instr"}, if_instr, instr);
      chk({tag, ".fault"}, 32'(if_fault), 32'(f));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(if_valid), 32'd0);
    chk({tag, ".instr"}, if_instr, NOP_INSTR);
    chk({tag, ".pc"}, if_pc, 32'd0);
    chk({tag, ".pc4"}, if_pc_plus4, 32'd0);
    chk({tag, ".fault"}, 32'(if_fault), 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
    chk({tag, ".addr"}, imem_addr, RESET_VECTOR);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
    logic        eh;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] tgt, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic ef, input logic eh, input logic [31:0] ea);
    vec_t r;
    r.rv = rv; r.tgt = tgt; r.rdy = rdy; r.ev = ev; r.epc = epc;
    r.einstr = ei; r.ef = ef; r.eh = eh; r.eaddr = ea;
    return r;
  endfunction

  // reference model state (random phase)
  logic [31:0] m_pc, m_ipc, m_instr;
  bit          m_v, m_f, m_halt;

  task automatic model_step(input logic rv, input logic [31:0] tgt, input logic rdy);
    longint off;
    bit     inr;
    off = longint'(m_pc) - longint'(ROM_BASE);
    inr = (off >= 0) && (off <= longint'(ROM_BYTES) - 4) && (m_pc % 4 == 0);
    if (rv) begin
      m_pc = tgt; m_v = 0; m_f = 0; m_halt = 0;
    end else if (m_halt) begin
      if (m_v && rdy) m_v = 0;
    end else if (!m_v || rdy) begin
      m_ipc = m_pc; m_v = 1;
      if (inr) begin
        m_instr = rom(m_pc); m_f = 0; m_pc = m_pc + 32'd4;
      end else begin
        m_instr = NOP_INSTR; m_f = 1; m_halt = 1;
      end
    end
  endtask

  vec_t tab[18];

  initial begin
    tab[0]  = mk(0, 0, 1, 1, 32'hBFC00000, 32'h11111111, 0, 0, 32'hBFC00004);
    tab[1]  = mk(0, 0, 1, 1, 32'hBFC00004, 32'h22222222, 0, 0, 32'hBFC00008);
    tab[2]  = mk(0, 0, 1, 1, 32'hBFC00008, 32'h33333333, 0, 0, 32'hBFC0000C);
    tab[3]  = mk(0, 0, 0, 1, 32'hBFC00008, 32'h33333333, 0, 0, 32'hBFC0000C);
    tab[4]  = mk(0, 0, 0, 1, 32'hBFC00008, 32'h33333333, 0, 0, 32'hBFC0000C);
    tab[5]  = mk(0, 0, 0, 1, 32'hBFC00008, 32'h33333333, 0, 0, 32'hBFC0000C);
    tab[6]  = mk(0, 0, 0, 1, 32'hBFC00008, 32'h33333333, 0, 0, 32'hBFC0000C);
    tab[7]  = mk(0, 0, 1, 1, 32'hBFC0000C, 32'hBFC0000C ^ 32'h5A5A5A5A, 0, 0, 32'hBFC00010);
    tab[8]  = mk(0, 0, 0, 1, 32'hBFC0000C, 32'hBFC0000C ^ 32'h5A5A5A5A, 0, 0, 32'hBFC00010);
    tab[9]  = mk(1, 32'hBFC00100, 0, 0, 0, 0, 0, 0, 32'hBFC00100);
    tab[10] = mk(0, 0, 0, 1, 32'hBFC00100, 32'hBFC00100 ^ 32'h5A5A5A5A, 0, 0, 32'hBFC00104);
    tab[11] = mk(1, 32'hBFC00102, 1, 0, 0, 0, 0, 0, 32'hBFC00102);
    tab[12] = mk(0, 0, 0, 1, 32'hBFC00102, NOP_INSTR, 1, 1, 32'hBFC00102);
    tab[13] = mk(0, 0, 0, 1, 32'hBFC00102, NOP_INSTR, 1, 1, 32'hBFC00102);
    tab[14] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hBFC00102);
    tab[15] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hBFC00102);
    tab[16] = mk(1, 32'hBFC00000, 1, 0, 0, 0, 0, 0, 32'hBFC00000);
    tab[17] = mk(0, 0, 1, 1, 32'hBFC00000, 32'h11111111, 0, 0, 32'hBFC00004);

    do_reset();
    chk_reset("rst");
    for (int i = 0; i < 18; i++) begin
      step(tab[i].rv, tab[i].tgt, tab[i].rdy);
      chk_out($sformatf("tab%0d", i), tab[i].ev, tab[i].epc, tab[i].einstr,
              tab[i].ef, tab[i].eh, tab[i].eaddr);
    end

    // last word of the window, then the first address past it
    step(1, ROM_BASE + ROM_BYTES - 8, 1);
    chk_out("edge.flush", 0, 0, 0, 0, 0, 32'hBFC00FF8);
    step(0, 0, 1);
    chk_out("edge.ff8", 1, 32'hBFC00FF8, 32'hBFC00FF8 ^ 32'h5A5A5A5A, 0, 0, 32'hBFC00FFC);
    step(0, 0, 1);
    chk_out("edge.ffc", 1, 32'hBFC00FFC, 32'hBFC00FFC ^ 32'h5A5A5A5A, 0, 0, 32'hBFC01000);
    step(0, 0, 1);
    chk_out("edge.flt", 1, 32'hBFC01000, NOP_INSTR, 1, 1, 32'hBFC01000);
    step(0, 0, 0);
    chk_out("edge.hold", 1, 32'hBFC01000, NOP_INSTR, 1, 1, 32'hBFC01000);

    // pc+4 wraps to zero
    step(1, 32'hFFFFFFFC, 1);
    step(0, 0, 1);
    chk_out("wrap", 1, 32'hFFFFFFFC, NOP_INSTR, 1, 1, 32'hFFFFFFFC);
    chk("wrap.pc4zero", if_pc_plus4, 32'd0);

    // redirect in the same cycle decode accepts an entry
    step(1, ROM_BASE, 1);
    step(0, 0, 1);
    chk_out("acc.v", 1, ROM_BASE, 32'h11111111, 0, 0, 32'hBFC00004);
    step(1, 32'hBFC00200, 1);
    chk_out("acc.flush", 0, 0, 0, 0, 0, 32'hBFC00200);
    step(0, 0, 1);
    chk_out("acc.tgt", 1, 32'hBFC00200, 32'hBFC00200 ^ 32'h5A5A5A5A, 0, 0, 32'hBFC00204);

    // asynchronous reset mid-stall, between edges
    step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst.stall");
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 1);
    chk_out("arst.restart", 1, 32'hBFC00000, 32'h11111111, 0, 0, 32'hBFC00004);

    // asynchronous reset mid-HALT
    step(1, 32'h0000_0000, 0);
    step(0, 0, 0);
    chk("halt.pre", 32'(halted), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst.halt");
    @(negedge clk);

    // randomized traffic against the reference model
    do_reset();
    m_pc = RESET_VECTOR; m_v = 0; m_f = 0; m_halt = 0; m_ipc = 0; m_instr = NOP_INSTR;
    for (int n = 0; n < 600; n++) begin
      logic        rv, rdy;
      logic [31:0] tgt;
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0: tgt = ROM_BASE + (32'($urandom_range(0, 1023)) << 2);
        1: tgt = ROM_BASE + ROM_BYTES - 8;
        2: tgt = ROM_BASE + (32'($urandom_range(0, 1023)) << 2) + 32'd2;
        3: tgt = $urandom;
        default: tgt = 32'hFFFFFFFC;
      endcase
      model_step(rv, tgt, rdy);
      step(rv, tgt, rdy);
      chk_out($sformatf("rnd%0d", n), m_v, m_ipc, m_instr, m_f, m_halt, m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the instruction ROM and feeds the decode stage. It holds the PC and drives the ROM byte address combinationally. The returned 32-bit word is captured, together with its PC, into an IF/ID register with a valid/ready handshake. It handles branch/jump redirects, decode back-pressure, and out-of-window or misaligned fetch faults.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
ROM_BASE, 32'hBFC00000, lowest legal fetch byte address
ROM_BYTES, 4096, size of the legal fetch window in bytes
NOP_INSTR, 32'h00000013, word substituted into if_instr on a fault (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  taken branch/jump from execute; flushes the stage
redirect_target  in  32  new PC, sampled when redirect_valid=1
id_ready  in  1  decode can accept the IF/ID entry this cycle
imem_addr  out  32  byte address to the ROM; equals pc (combinational)
imem_rdata  in  32  ROM word for imem_addr, same cycle (combinational ROM)
if_valid  out  1  IF/ID entry valid
if_instr  out  32  fetched instruction
if_pc  out  32  PC of if_instr
if_pc_plus4  out  32  if_pc + 4, modulo 2^32
if_fault  out  1  entry is a fault marker (if_instr = NOP_INSTR)
halted  out  1  stage is in HALT state

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_VECTOR, state=RUN.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=0, if_fault=0, halted=0.
- Release is synchronous to the next edge. The first fetch is captured on the first rising edge with rst_n=1.
- in_range = (pc >= ROM_BASE) && (pc - ROM_BASE <= ROM_BYTES-4) && (pc[1:0] == 0). Use 33-bit compares so there is no wrap.
- advance = !if_valid || id_ready.
- Priority at each edge: reset > redirect > stall > fetch.
- redirect_valid=1, in any state and regardless of id_ready:
  - pc <= redirect_target; if_valid <= 0; if_fault <= 0; state <= RUN.
  - The word on imem_rdata this cycle is discarded.
- RUN, advance=0 (stall): pc and the IF/ID register hold. Outputs stay stable while if_valid=1 and id_ready=0.
- RUN, advance=1, in_range:
  - IF/ID <= {imem_rdata, pc, pc+4, fault=0}; if_valid <= 1; pc <= pc+4.
  - Throughput is one instruction per cycle.
- RUN, advance=1, !in_range:
  - IF/ID <= {NOP_INSTR, pc, pc+4, fault=1}; if_valid <= 1; pc holds; state <= HALT.
  - imem_rdata is ignored.
- HALT:
  - No fetch; halted=1; pc holds.
  - The fault entry stays valid until accepted (id_ready=1), then if_valid <= 0.
  - Only a redirect or reset leaves HALT.
- Latency: PC to if_valid is 1 cycle. Redirect to the first valid target entry is 2 edges (flush edge, then capture edge).
- Boundaries:
  - pc = ROM_BASE+ROM_BYTES-4 fetches normally. The next pc is out of window and faults.
  - pc+4 at 32'hFFFFFFFC wraps to 0, which is out of window and faults.
  - A redirect arriving in the same cycle the decode stage accepts an entry: the entry is consumed, and the IF/ID register is cleared by the redirect.
  - Reset asserted mid-stall or mid-HALT returns all state to reset values immediately.

Decomposition:
- Shared package riscv_pkg:
  - ROM_BASE, ROM_BYTES, NOP_INSTR, RESET_VECTOR constants.
  - enum fetch_state_t {RUN, HALT}.
  - struct if_id_t {instr[31:0], pc[31:0], pc_plus4[31:0], fault}.
- One sub-module, if_id_reg: the pipeline register with load/flush/hold controls, asynchronous active-low reset, and the valid bit.
- PC logic, range check and FSM live in fetch_stage.

Test Plan:
- Reset then id_ready=1 for 3 cycles, ROM words 11111111/22222222/33333333 -> if_pc = BFC00000, BFC00004, BFC00008 on consecutive cycles, matching if_instr, if_fault=0.
- id_ready=0 for 4 cycles with if_valid=1 -> if_pc, if_instr and imem_addr unchanged; after id_ready=1 resumes at the next sequential PC with no skipped or duplicated PC.
- Redirect to BFC00100 during a stall -> next edge if_valid=0; following edge if_valid=1, if_pc=BFC00100.
- Redirect to BFC00102 (misaligned) -> entry with if_fault=1, if_instr=00000013, if_pc=BFC00102; halted=1; no further fetches until a redirect to BFC00000 restarts fetching.
- Sequential fetch through BFC00FFC -> normal entry; then fault entry at if_pc=BFC01000, halted=1.
- rst_n pulsed low mid-stream, asynchronously between edges -> outputs hit reset values without a clock edge; fetch restarts at BFC00000.
